// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, single-entry output holding register
// and valid/ready handshake; flags framing errors and dropped bytes as pulses.
module uart_rx #(
   parameter int CLK_FREQ = 12000000,
   parameter int BAUD     = 9600
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] byte_received,
   output logic       valid,
   input  logic       ready,
   output logic       framing_error,
   output logic       overrun
);

   localparam int CLKS_PER_TICK = CLK_FREQ / (16 * BAUD);
   localparam int TICK_W = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_TICK - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state_reg, state_next;
   logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
   logic [3:0]        sample_cnt_reg, sample_cnt_next;
   logic [2:0]        bit_idx_reg, bit_idx_next;
   logic [7:0]        shift_reg, shift_next;
   logic [7:0]        byte_reg, byte_next;
   logic              valid_reg, valid_next;
   logic              framing_error_reg, framing_error_next;
   logic              overrun_reg, overrun_next;
   logic              rx_meta_reg, rx_sync_reg, rx_prev_reg;
   logic              tick;
   logic              fall;

   // Synchronizer plus one history flop for falling-edge detection; idle-high on reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta_reg <= 1'b1;
         rx_sync_reg <= 1'b1;
         rx_prev_reg <= 1'b1;
      end else begin
         rx_meta_reg <= rx;
         rx_sync_reg <= rx_meta_reg;
         rx_prev_reg <= rx_sync_reg;
      end
   end

   assign tick = (tick_cnt_reg == TICK_LAST);
   assign fall = rx_prev_reg & ~rx_sync_reg;

   always_comb begin
      state_next         = state_reg;
      tick_cnt_next      = tick_cnt_reg;
      sample_cnt_next    = sample_cnt_reg;
      bit_idx_next       = bit_idx_reg;
      shift_next         = shift_reg;
      byte_next          = byte_reg;
      valid_next         = valid_reg;
      framing_error_next = 1'b0;
      overrun_next       = 1'b0;

      if (state_reg == IDLE) begin
         tick_cnt_next = '0;
      end else if (tick) begin
         tick_cnt_next = '0;
      end else begin
         tick_cnt_next = tick_cnt_reg + TICK_W'(1);
      end

      if (valid_reg && ready) begin
         valid_next = 1'b0;
      end

      case (state_reg)
         IDLE: begin
            sample_cnt_next = 4'd0;
            if (fall) begin
               state_next = START;
            end
         end
         START: begin
            if (tick) begin
               if (sample_cnt_reg == 4'd7) begin
                  sample_cnt_next = 4'd0;
                  if (!rx_sync_reg) begin
                     state_next   = DATA;
                     bit_idx_next = 3'd0;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  sample_cnt_next = sample_cnt_reg + 4'd1;
               end
            end
         end
         DATA: begin
            if (tick) begin
               sample_cnt_next = sample_cnt_reg + 4'd1;
               if (sample_cnt_reg == 4'd15) begin
                  shift_next   = {rx_sync_reg, shift_reg[7:1]};
                  bit_idx_next = bit_idx_reg + 3'd1;
                  if (bit_idx_reg == 3'd7) begin
                     state_next = STOP;
                  end
               end
            end
         end
         STOP: begin
            if (tick) begin
               sample_cnt_next = sample_cnt_reg + 4'd1;
               if (sample_cnt_reg == 4'd15) begin
                  state_next = IDLE;
                  // A consumer taking the old byte this cycle frees the slot for the new one.
                  if (rx_sync_reg) begin
                     if (!valid_reg || ready) begin
                        byte_next  = shift_reg;
                        valid_next = 1'b1;
                     end else begin
                        overrun_next = 1'b1;
                     end
                  end else begin
                     framing_error_next = 1'b1;
                  end
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg         <= IDLE;
         tick_cnt_reg      <= '0;
         sample_cnt_reg    <= 4'd0;
         bit_idx_reg       <= 3'd0;
         shift_reg         <= 8'h00;
         byte_reg          <= 8'h00;
         valid_reg         <= 1'b0;
         framing_error_reg <= 1'b0;
         overrun_reg       <= 1'b0;
      end else begin
         state_reg         <= state_next;
         tick_cnt_reg      <= tick_cnt_next;
         sample_cnt_reg    <= sample_cnt_next;
         bit_idx_reg       <= bit_idx_next;
         shift_reg         <= shift_next;
         byte_reg          <= byte_next;
         valid_reg         <= valid_next;
         framing_error_reg <= framing_error_next;
         overrun_reg       <= overrun_next;
      end
   end

   assign byte_received = byte_reg;
   assign valid         = valid_reg;
   assign framing_error = framing_error_reg;
   assign overrun       = overrun_reg;

endmodule
